// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL
  } state_t;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned DEF_LINES = 16;
  localparam int unsigned DEF_WORDS = 4;

  typedef logic [WORD_W-1:0] word_t;

  // Line type for the default geometry; parameterised instances size lines as WORD_W*WORDS.
  typedef logic [WORD_W*DEF_WORDS-1:0] line_t;

  // Byte-offset bits within a line: word select plus the two byte bits.
  function automatic int unsigned off_bits(input int unsigned words);
    return $clog2(words) + 2;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned lines,
                                           input int unsigned words);
    return addr_w - off_bits(words) - idx_bits(lines);
  endfunction

  // Word-select width, kept at least one bit so single-word lines still elaborate.
  function automatic int unsigned sel_bits(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: one asynchronous read port, a full-line refill
// port, a single-word store port and a dirty-clear port. Valid and dirty bits
// clear synchronously on reset; tags and data are left as they are.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned TAG_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [WORD_W*WORDS-1:0]  rd_line,
  input  logic                     lw_en,
  input  logic [$clog2(LINES)-1:0] lw_idx,
  input  logic [TAG_W-1:0]         lw_tag,
  input  logic [WORD_W*WORDS-1:0]  lw_line,
  input  logic                     ww_en,
  input  logic [$clog2(LINES)-1:0] ww_idx,
  input  logic [sel_bits(WORDS)-1:0] ww_sel,
  input  logic [WORD_W-1:0]        ww_data,
  input  logic                     dc_en,
  input  logic [$clog2(LINES)-1:0] dc_idx
);

  logic [LINES-1:0]        valid_q;
  logic [LINES-1:0]        dirty_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [WORD_W*WORDS-1:0] data_q [LINES];

  // Combinational read of the selected line.
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_dirty = dirty_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_line  = data_q[rd_idx];
  end

  // Line refill, word store and dirty clear; reset drops every valid and dirty bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (lw_en) begin
        valid_q[lw_idx] <= 1'b1;
        dirty_q[lw_idx] <= 1'b0;
        tag_q[lw_idx]   <= lw_tag;
        data_q[lw_idx]  <= lw_line;
      end
      if (ww_en) begin
        data_q[ww_idx][WORD_W*int'(ww_sel) +: WORD_W] <= ww_data;
        dirty_q[ww_idx] <= 1'b1;
      end
      if (dc_en) begin
        dirty_q[dc_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller for the M-stage load/store port.
// Optional build macro DCACHE_STATS_EN adds stat_hits/stat_misses/stat_wbs counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES  = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_rd,
  input  logic                    req_wr,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    hit,
  output logic                    miss,
  output logic                    dirty,
  output logic                    done,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [32*WORDS-1:0]     mem_wdata,
  input  logic [32*WORDS-1:0]     mem_rdata,
  input  logic                    mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses,
  output logic [31:0]             stat_wbs
`endif
);

  localparam int unsigned OFF_W = off_bits(WORDS);
  localparam int unsigned IDX_W = idx_bits(LINES);
  localparam int unsigned TAG_W = tag_bits(ADDR_W, LINES, WORDS);
  localparam int unsigned SEL_W = sel_bits(WORDS);
  localparam logic [OFF_W-1:0] OFF_ZERO = '0;

  state_t state_q, state_d;

  logic             op_wr_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      wdata_q;

  logic hit_q, miss_q, dirty_q;

  logic [IDX_W-1:0] in_idx;
  logic [TAG_W-1:0] in_tag;
  logic [SEL_W-1:0] in_sel;
  logic             req_any;
  logic             accept;
  logic             lookup_hit;
  logic             unused_addr_bits;

  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [32*WORDS-1:0]   rd_line;
  logic                  lw_en, ww_en, dc_en;

  assign in_idx           = addr[OFF_W +: IDX_W];
  assign in_tag           = addr[OFF_W+IDX_W +: TAG_W];
  assign in_sel           = addr[2 +: SEL_W];
  assign unused_addr_bits = ^addr[1:0];
  assign req_any          = req_rd | req_wr;
  assign accept           = (state_q == S_IDLE) && req_any;

  // The tag check is done against the incoming address while idle so the
  // registered hit/miss/dirty are already valid in the first LOOKUP cycle.
  assign rd_idx     = (state_q == S_IDLE) ? in_idx : idx_q;
  assign lookup_hit = rd_valid && (rd_tag == in_tag);

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .lw_en    (lw_en),
    .lw_idx   (idx_q),
    .lw_tag   (tag_q),
    .lw_line  (mem_rdata),
    .ww_en    (ww_en),
    .ww_idx   (idx_q),
    .ww_sel   (sel_q),
    .ww_data  (wdata_q),
    .dc_en    (dc_en),
    .dc_idx   (idx_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Capture the request when it is accepted; a simultaneous read and write is a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_wr_q <= 1'b0;
      tag_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_wr_q <= req_wr & ~req_rd;
      tag_q   <= in_tag;
      idx_q   <= in_idx;
      sel_q   <= in_sel;
      wdata_q <= wdata;
    end
  end

  // Lookup status registers; a refill forces the following re-lookup to hit on a clean line.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      dirty_q <= 1'b0;
    end else if (accept) begin
      hit_q   <= lookup_hit;
      miss_q  <= ~lookup_hit;
      dirty_q <= rd_dirty;
    end else if (state_q == S_FILL && mem_ack) begin
      hit_q   <= 1'b1;
      miss_q  <= 1'b0;
      dirty_q <= 1'b0;
    end
  end

  assign hit   = hit_q;
  assign miss  = miss_q;
  assign dirty = dirty_q;
  assign stall = req_any & ~done;

  // Next-state, memory-bus and array-write control.
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    rdata     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    lw_en     = 1'b0;
    ww_en     = 1'b0;
    dc_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
          if (op_wr_q) ww_en = 1'b1;
          else         rdata = rd_line[32*int'(sel_q) +: 32];
        end else if (dirty_q) begin
          state_d = S_WB;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, idx_q, OFF_ZERO};
        mem_wdata = rd_line;
        if (mem_ack) begin
          dc_en   = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, idx_q, OFF_ZERO};
        if (mem_ack) begin
          lw_en   = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic relook_q;

  // Marks the LOOKUP that follows a refill so it is not counted a second time.
  always_ff @(posedge clk) begin
    if (reset)                             relook_q <= 1'b0;
    else if (state_q == S_FILL && mem_ack) relook_q <= 1'b1;
    else if (accept)                       relook_q <= 1'b0;
  end

  // Access statistics; all counters wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
    end else begin
      if (state_q == S_LOOKUP && !relook_q && hit_q)  stat_hits   <= stat_hits + 32'd1;
      if (state_q == S_LOOKUP && !relook_q && miss_q) stat_misses <= stat_misses + 32'd1;
      if (state_q == S_WB && mem_ack)                 stat_wbs    <= stat_wbs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a vector table of accesses with hand-computed
// results plus hand sequences for stray acks, back-to-back requests and reset mid-fill.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_rd, req_wr;
  logic [31:0]  addr, wdata, rdata;
  logic         hit, miss, dirty, done, stall;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  stat_hits, stat_misses, stat_wbs;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(16), .WORDS(4), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .hit       (hit),
    .miss      (miss),
    .dirty     (dirty),
    .done      (done),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_wbs    (stat_wbs)
`endif
  );

  typedef struct {
    bit           rd, wr;
    logic [31:0]  a, wd;
    logic [127:0] line;
    int           dw, df;
    bit           e_hit, e_dirty;
    logic [31:0]  e_rdata;
    int           e_lat;
    bit           e_wb;
    logic [31:0]  e_wbaddr, e_wbw0;
    bit           e_fill;
    logic [31:0]  e_filladdr;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  bit          o_hit, o_miss, o_dirty, o_memreq, o_wb, o_fill, o_gap;
  bit          o_stall_done, o_stall_low, o_timeout;
  logic [31:0] o_rdata, o_wbaddr, o_wbw0, o_filladdr;
  int          o_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [127:0] line,
                              input int dw, input int df, input bit e_hit,
                              input bit e_dirty, input logic [31:0] e_rdata,
                              input int e_lat, input bit e_wb,
                              input logic [31:0] e_wbaddr, input logic [31:0] e_wbw0,
                              input bit e_fill, input logic [31:0] e_filladdr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.line = line; v.dw = dw; v.df = df;
    v.e_hit = e_hit; v.e_dirty = e_dirty; v.e_rdata = e_rdata; v.e_lat = e_lat;
    v.e_wb = e_wb; v.e_wbaddr = e_wbaddr; v.e_wbw0 = e_wbw0;
    v.e_fill = e_fill; v.e_filladdr = e_filladdr;
    return v;
  endfunction

  // Drive one access and act as memory: ack a writeback dw cycles and a refill
  // df cycles after the phase's first mem_req cycle.
  task automatic run_access(input vec_t v);
    int cyc;
    int phase;
    o_hit = 0; o_miss = 0; o_dirty = 0; o_memreq = 0; o_wb = 0; o_fill = 0; o_gap = 0;
    o_stall_done = 1; o_stall_low = 0; o_timeout = 0;
    o_rdata = '0; o_wbaddr = '0; o_wbw0 = '0; o_filladdr = '0; o_lat = -1;
    @(negedge clk);
    req_rd = v.rd; req_wr = v.wr; addr = v.a; wdata = v.wd;
    cyc = 0;
    phase = 0;
    while (1) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      mem_ack = 1'b0;
      if (cyc == 1) begin
        o_hit = hit; o_miss = miss; o_dirty = dirty;
      end
      if (done) begin
        o_lat = cyc; o_rdata = rdata; o_stall_done = stall;
        req_rd = 1'b0; req_wr = 1'b0;
        break;
      end
      if (!stall) o_stall_low = 1;
      if (mem_req) begin
        o_memreq = 1;
        if (mem_we) begin
          if (!o_wb) begin
            o_wbaddr = mem_addr;
            o_wbw0   = mem_wdata[31:0];
          end
          o_wb = 1;
          if (phase == v.dw) begin mem_ack = 1'b1; phase = 0; end
          else phase++;
        end else begin
          if (!o_fill) o_filladdr = mem_addr;
          o_fill = 1;
          if (phase == v.df) begin mem_ack = 1'b1; mem_rdata = v.line; phase = 0; end
          else phase++;
        end
      end else if (o_wb && !o_fill) begin
        o_gap = 1;
      end
      if (cyc >= 200) begin
        o_timeout = 1;
        req_rd = 1'b0; req_wr = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_vec(input string t, input vec_t v);
    check({t, ".timeout"}, o_timeout, 0);
    check({t, ".hit"}, o_hit, v.e_hit);
    check({t, ".miss"}, o_miss, !v.e_hit);
    check({t, ".dirty"}, o_dirty, v.e_dirty);
    check({t, ".latency"}, o_lat, v.e_lat);
    check({t, ".stall_at_done"}, o_stall_done, 0);
    check({t, ".stall_before_done"}, o_stall_low, 0);
    check({t, ".mem_req_seen"}, o_memreq, v.e_fill);
    check({t, ".wb_seen"}, o_wb, v.e_wb);
    if (v.rd) check({t, ".rdata"}, o_rdata, v.e_rdata);
    if (v.e_wb) begin
      check({t, ".wb_addr"}, o_wbaddr, v.e_wbaddr);
      check({t, ".wb_word0"}, o_wbw0, v.e_wbw0);
      check({t, ".wb_fill_gap"}, o_gap, 0);
    end
    if (v.e_fill) check({t, ".fill_addr"}, o_filladdr, v.e_filladdr);
  endtask

  task automatic check_stats(input string t, input int h, input int m, input int w);
`ifdef DCACHE_STATS_EN
    check({t, ".stat_hits"}, stat_hits, h);
    check({t, ".stat_misses"}, stat_misses, m);
    check({t, ".stat_wbs"}, stat_wbs, w);
`else
    if (h < 0 || m < 0 || w < 0) $display("negative stat expectation in %s", t);
`endif
  endtask

  localparam logic [127:0] L1234 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] L5678 = {32'd8, 32'd7, 32'd6, 32'd5};
  localparam logic [127:0] L9_12 = {32'd12, 32'd11, 32'd10, 32'd9};
  localparam logic [127:0] LD234 = {32'd4, 32'd3, 32'd2, 32'hDEAD};

  // Watchdog so the bench cannot hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    vec_t v;
    bit   seen;

    vecs[0] = mk(1, 0, 32'h104, 0, L1234, 0, 20, 0, 0, 32'd2, 23, 0, 0, 0, 1, 32'h100);
    vecs[1] = mk(1, 0, 32'h108, 0, '0, 0, 0, 1, 0, 32'd3, 1, 0, 0, 0, 0, 0);
    vecs[2] = mk(0, 1, 32'h100, 32'hDEAD, '0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[3] = mk(1, 0, 32'h100, 0, '0, 0, 0, 1, 1, 32'hDEAD, 1, 0, 0, 0, 0, 0);
    vecs[4] = mk(1, 0, 32'h200, 0, L5678, 3, 3, 0, 1, 32'd5, 10, 1, 32'h100, 32'hDEAD, 1, 32'h200);
    vecs[5] = mk(1, 1, 32'h208, 32'hBAD, '0, 0, 0, 1, 0, 32'd7, 1, 0, 0, 0, 0, 0);
    vecs[6] = mk(1, 0, 32'h208, 0, '0, 0, 0, 1, 0, 32'd7, 1, 0, 0, 0, 0, 0);
    vecs[7] = mk(0, 1, 32'h3FC, 32'h1234, L9_12, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 32'h3F0);
    vecs[8] = mk(1, 0, 32'h3FC, 0, '0, 0, 0, 1, 1, 32'h1234, 1, 0, 0, 0, 0, 0);
    vecs[9] = mk(1, 0, 32'h100, 0, LD234, 0, 2, 0, 0, 32'hDEAD, 5, 0, 0, 0, 1, 32'h100);

    reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.hit", hit, 0);
    check("reset.miss", miss, 0);
    check("reset.dirty", dirty, 0);
    check("reset.done", done, 0);
    check("reset.stall", stall, 0);
    check("reset.rdata", rdata, 0);
    check("reset.mem_req", mem_req, 0);
    check("reset.mem_we", mem_we, 0);
    check("reset.mem_addr", mem_addr, 0);
    check("reset.mem_wdata_lo", mem_wdata[63:0], 0);
    check("reset.mem_wdata_hi", mem_wdata[127:64], 0);
    check_stats("reset", 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_access(vecs[i]);
      check_vec($sformatf("v%0d", i), vecs[i]);
      if (i == 4) check_stats("after_v4", 3, 2, 1);
    end
    check_stats("after_table", 6, 4, 1);

    // Stray ack while idle must not touch the cache or the bus.
    @(negedge clk);
    mem_rdata = '1;
    mem_ack   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray.mem_req", mem_req, 0);
    check("stray.done", done, 0);
    v = mk(1, 0, 32'h108, 0, '0, 0, 0, 1, 0, 32'd3, 1, 0, 0, 0, 0, 0);
    run_access(v);
    check_vec("stray_read", v);

    // Held request: done pulses every other cycle, stall low only with done.
    @(negedge clk);
    req_rd = 1'b1; addr = 32'h104;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b.c%0d.done", c), done, (c % 2));
      check($sformatf("b2b.c%0d.stall", c), stall, 1 - (c % 2));
      if (c % 2 == 1) check($sformatf("b2b.c%0d.rdata", c), rdata, 32'd2);
      if (c == 4) req_rd = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("b2b.idle_done", done, 0);

    // Reset while a refill is outstanding.
    req_rd = 1'b1; addr = 32'h504;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_req) begin
        seen = 1;
        break;
      end
    end
    check("rst_fill.mem_req_seen", seen, 1);
    check("rst_fill.mem_we", mem_we, 0);
    check("rst_fill.mem_addr", mem_addr, 32'h500);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; req_rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_fill.mem_req_after", mem_req, 0);
    check("rst_fill.done_after", done, 0);
    check("rst_fill.hit_after", hit, 0);
    check("rst_fill.miss_after", miss, 0);
    check_stats("rst_fill", 0, 0, 0);
    reset = 1'b0;
    v = mk(1, 0, 32'h108, 0, L1234, 0, 1, 0, 0, 32'd3, 4, 0, 0, 0, 1, 32'h100);
    run_access(v);
    check_vec("post_reset", v);
    check_stats("post_reset", 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back data cache controller serving the M-stage load/store port of the pipeline and driving the main-memory bus. It performs tag lookup, returns `hit`/`miss`/`dirty` status and the stall request consumed by hazard control, and runs the dirty-line writeback and line refill transactions on the memory side. Each access completes with a single-cycle `done` pulse.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two.
- `ADDR_W`, 32: byte address width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_rd`  in  1  load request, driven by memtoreg in M.
- `req_wr`  in  1  store request, driven by memwrite in M.
- `addr`  in  ADDR_W  byte address; word-aligned.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data; valid while `done`=1.
- `hit`  out  1  registered lookup result.
- `miss`  out  1  registered lookup result.
- `dirty`  out  1  registered dirty bit of the indexed line.
- `done`  out  1  one-cycle access-complete pulse.
- `stall`  out  1  combinational: (`req_rd`|`req_wr`) & ~`done`.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = writeback, 0 = refill.
- `mem_addr`  out  ADDR_W  line-aligned address.
- `mem_wdata`  out  32*WORDS  writeback line.
- `mem_rdata`  in  32*WORDS  refill line; valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse from memory.

## Operation
- Address split: offset = log2(WORDS)+2 bits, index = log2(LINES) bits, tag = remainder. Word `i` of a line occupies `mem_*data[32*i+31:32*i]`.
- FSM states: IDLE, LOOKUP, WB, FILL.
- IDLE: on `req_rd`|`req_wr`, capture op, address and data, then go to LOOKUP. If both are set, the access is a read; no write occurs.
- LOOKUP: register `hit` = valid & tag match, `miss` = ~`hit`, and `dirty`.
  - On hit: a read drives `rdata`; a write updates the word and sets the dirty bit. Assert `done` and return to IDLE.
  - On miss with a dirty victim: go to WB.
  - On miss with a clean or invalid victim: go to FILL.
- WB: hold `mem_req`=1 and `mem_we`=1, with `mem_addr` = {victim tag, index, 0} and `mem_wdata` = victim line. On `mem_ack`, clear dirty and go to FILL.
- FILL: hold `mem_req`=1 and `mem_we`=0, with `mem_addr` = request line address. On `mem_ack`, write the line, set valid, load the tag, clear dirty, and go to LOOKUP. The re-lookup then hits.
- Requests are sampled only in IDLE. The requester holds the request until `done`. Dropping a request mid-operation does not abort the current operation.
- `mem_ack` is ignored whenever `mem_req`=0.

## Timing
- Reset values: every output is 0, all valid and dirty bits are 0, state = IDLE, statistics counters = 0.
- Reset mid-transaction: `mem_req` is 0 in the cycle after the reset edge. Any in-flight line is discarded.
- Hit latency: request in cycle 0 (IDLE); `hit` and `done` in cycle 1.
- Clean miss: `mem_req` from cycle 2. With `mem_ack` in cycle N, LOOKUP is in N+1 and `done` is in N+1.
- Dirty miss: the writeback handshake completes first, then `mem_req` stays asserted without a gap, with `mem_we` falling to 0.
- `done` never asserts in two consecutive cycles. A back-to-back request is accepted in the cycle after `done`.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `stat_hits`, `stat_misses` and `stat_wbs`, each 32 bits.
  - `stat_hits` increments on every first LOOKUP that hits.
  - `stat_misses` increments on every first LOOKUP that misses.
  - `stat_wbs` increments on every WB `mem_ack`.
  - A re-lookup after FILL is not counted. All counters wrap and reset to 0.
- `DCACHE_STATS_EN` undefined: the counters and their ports are absent. Behaviour is otherwise identical.

## Structure
- Package `dcache_pkg`: FSM state enum, derived widths (offset, index, tag), and the line typedef.
- Sub-module `dcache_array`: valid/dirty/tag/data storage with one read port plus line-write and word-write ports, and synchronous clear on `reset`.

## Test plan
- Cold read of 0x104: WB skipped; `mem_addr`=0x100, `mem_we`=0. Memory acks 20 cycles later with words {1,2,3,4} → `rdata`=2 and `done` in the cycle after the ack.
- Read of 0x108 immediately after → `hit`=1, `rdata`=3, `done` in cycle 1, no `mem_req`.
- Write 0xDEAD to 0x100 → hit, `done` in cycle 1. A following read of 0x100 returns 0xDEAD.
- Read of 0x200 (same index, LINES=16) → `miss`=1 and `dirty`=1. WB issues `mem_addr`=0x100 with word0 = 0xDEAD, then FILL at 0x200 with no idle gap, then `done`.
- `reset` during FILL → `mem_req`=0 next cycle. A later read of 0x108 misses.
- A stray `mem_ack` in IDLE produces no state change. With `DCACHE_STATS_EN` defined, the sequence above yields hits=3, misses=2, wbs=1 before the reset.
